// File: rtl/keccak_padder_param.sv
// keccak_padder_param
//
// Collects 64-bit message words into one rate-sized Keccak block and applies
// the multi-rate padding: a domain-separation byte (SUFFIX) after the last
// message byte, zero fill, and 0x80 in the final byte of the block.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in           message word, first byte in bits [63:56]
//   in_ready     in is valid this cycle
//   is_last      in is the final word of the message
//   byte_num     valid bytes in the final word (0..7)
//   mode         rate select: 0->18, 1->17, 2->13, 3->9 words
//   f_ack        consumer takes the presented block
//   buffer_full  padder cannot accept a word this cycle
//   out          block; word i at out[64*MAXW-1-64*i -: 64], words >= rate are zero
//   out_ready    out holds a complete block
//   out_last     the presented block is the final block of the message
//
// MAXW must be at least 18 (the largest rate).

module keccak_padder_param #(
    parameter logic [7:0] SUFFIX = 8'h06,
    parameter int         MAXW   = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         in,
    input  logic                in_ready,
    input  logic                is_last,
    input  logic [2:0]          byte_num,
    input  logic [1:0]          mode,
    input  logic                f_ack,
    output logic                buffer_full,
    output logic [64*MAXW-1:0]  out,
    output logic                out_ready,
    output logic                out_last
);

    localparam int CW = $clog2(MAXW + 1);

    typedef enum logic [1:0] {FILL, PAD, FULL, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    mode_q;
    logic          started;
    logic [63:0]   words [MAXW];
    logic [CW-1:0] rate;
    logic          at_end;

    function automatic logic [CW-1:0] rate_of(input logic [1:0] m);
        logic [CW-1:0] r;
        case (m)
            2'd0:    r = CW'(18);
            2'd1:    r = CW'(17);
            2'd2:    r = CW'(13);
            default: r = CW'(9);
        endcase
        return r;
    endfunction

    // Keep the first k bytes, place SUFFIX at byte k, zero the rest.
    function automatic logic [63:0] pad_last(input logic [63:0] w, input logic [2:0] k);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(k))
                r[63-8*j -: 8] = w[63-8*j -: 8];
            else if (j == int'(k))
                r[63-8*j -: 8] = SUFFIX;
        end
        return r;
    endfunction

    // The live mode decides the rate only until the first word of the
    // message is taken; from then on the latched copy is used.
    assign rate   = started ? rate_of(mode_q) : rate_of(mode);
    assign at_end = (cnt == rate - CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FILL;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        buffer_full = 1'b0;
        out_ready   = 1'b0;
        case (state)
            FILL: begin
                if (in_ready) begin
                    if (is_last)
                        state_next = at_end ? FULL : PAD;
                    else if (at_end)
                        state_next = FULL;
                end
            end
            PAD: begin
                buffer_full = 1'b1;
                if (at_end)
                    state_next = FULL;
            end
            FULL: begin
                buffer_full = 1'b1;
                out_ready   = 1'b1;
                if (f_ack)
                    state_next = out_last ? DONE : FILL;
            end
            default: begin
                state_next = DONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            mode_q   <= 2'd3;
            started  <= 1'b0;
            out_last <= 1'b0;
            for (int i = 0; i < MAXW; i++)
                words[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_ready) begin
                        if (!started) begin
                            mode_q  <= mode;
                            started <= 1'b1;
                        end
                        if (is_last) begin
                            // A last word landing in the final slot also carries the closing 0x80.
                            words[cnt] <= pad_last(in, byte_num) | (at_end ? 64'h80 : 64'h0);
                            if (at_end)
                                out_last <= 1'b1;
                        end else begin
                            words[cnt] <= in;
                        end
                        cnt <= cnt + CW'(1);
                    end
                end
                PAD: begin
                    words[cnt] <= at_end ? 64'h80 : 64'h0;
                    cnt        <= cnt + CW'(1);
                    if (at_end)
                        out_last <= 1'b1;
                end
                FULL: begin
                    if (f_ack) begin
                        cnt      <= '0;
                        out_last <= 1'b0;
                        for (int i = 0; i < MAXW; i++)
                            words[i] <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar i = 0; i < MAXW; i++) begin : g_out
        assign out[64*MAXW-1-64*i -: 64] = words[i];
    end

endmodule

// File: doc/keccak_padder_param.md
KECCAK_PADDER_PARAM -- requirements
Module: keccak_padder_param

Interface
REQ-001 SHALL have parameter SUFFIX, default 8'h06; the domain-separation byte (8'h06 for SHA3, 8'h01 for Keccak, 8'h1F for SHAKE).
REQ-002 SHALL have parameter MAXW, default 18; the width of out in 64-bit words, fixed to the largest rate.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-005 SHALL have port in, input, 64 bits; message word, first byte in bits [63:56].
REQ-006 SHALL have port in_ready, input, 1 bit; in is valid.
REQ-007 SHALL have port is_last, input, 1 bit; in is the final word of the message.
REQ-008 SHALL have port byte_num, input, 3 bits; valid bytes in the final word (0..7), ignored when is_last=0.
REQ-009 SHALL have port mode, input, 2 bits; rate select R words: 0->18, 1->17, 2->13, 3->9.
REQ-010 SHALL have port f_ack, input, 1 bit; the consumer takes the presented block.
REQ-011 SHALL have port buffer_full, output, 1 bit; the padder cannot accept in this cycle.
REQ-012 SHALL have port out, output, 64*MAXW bits; block with word i at out[64*MAXW-1-64*i -: 64], words >= R zero.
REQ-013 SHALL have port out_ready, output, 1 bit; out holds a complete block.
REQ-014 SHALL have port out_last, output, 1 bit; the presented block is the final block of the message.

Function
REQ-015 SHALL implement states FILL, PAD, FULL and DONE.
REQ-016 A word SHALL be accepted on a rising edge when state=FILL and in_ready=1; buffer_full=1 exactly in PAD and FULL.
REQ-017 mode SHALL be latched when word 0 of the message is accepted and held until reset; later mode changes have no effect.
REQ-018 A non-last accepted word SHALL be stored unchanged at index cnt, then cnt increments; when cnt reaches R, next state is FULL with out_last=0.
REQ-019 For a last word with byte_num=k: bytes 0..k-1 SHALL come from in, byte k SHALL equal SUFFIX, and bytes k+1..7 SHALL be zero.
REQ-020 After a last word at index R-1, byte 7 of that word SHALL be OR'd with 8'h80 and next state SHALL be FULL with out_last=1.
REQ-021 After a last word below index R-1, next state SHALL be PAD.
REQ-022 PAD SHALL write one zero word per cycle; word R-1 SHALL be 64'h80; it then moves to FULL with out_last=1.
REQ-023 out_ready SHALL be 1 only in FULL; it rises the cycle after the final word (data or pad) of the block is written.
REQ-024 In FULL, f_ack=1 SHALL clear all words and cnt; next state is FILL if out_last=0, else DONE.
REQ-025 f_ack outside FULL SHALL be ignored.
REQ-026 Input is never accepted in the cycle of f_ack.
REQ-027 In DONE: buffer_full=0, out_ready=0, and in, is_last and f_ack are ignored until reset.
REQ-028 is_last=1 with byte_num=0 SHALL still consume one word slot holding only SUFFIX in byte 0.
REQ-029 A message whose data fills a block exactly SHALL require a further last word to close it (the padding block).
REQ-030 out SHALL be held stable while out_ready=1.

Reset
REQ-031 reset=1 SHALL immediately force state FILL, cnt=0, latched mode=3, all out words 0, out_ready=0, out_last=0 and buffer_full=0, from any state including mid-PAD or FULL.
REQ-032 The first rising edge after reset deasserts SHALL be able to accept a word.

Verification
REQ-033 mode=3, in=64'hA1A2A3A4A5000000, byte_num=5, is_last=1 -> word0=64'hA1A2A3A4A5060000, words 1..7=0, word8=64'h80, out_ready 9 cycles after acceptance, out_last=1.
REQ-034 mode=3, 8 words 64'hEFCDAB9078563412, then a 9th with is_last=1, byte_num=7 -> word8=64'hEFCDAB9078563486, out_ready next cycle.
REQ-035 mode=3, 9 non-last words, 10th held with in_ready=1 -> buffer_full=1 and 10th not taken until f_ack; then is_last with byte_num=0 -> second block word0=64'h0600000000000000, word8=64'h80, out_last=1.
REQ-036 mode=0 at word 0, mode=3 during the message, single last word -> padding runs to word 17=64'h80, 18 cycles to out_ready, words 18+ zero.
REQ-037 reset pulse mid-PAD -> out_ready=0 and cnt=0 immediately, next message correct.
REQ-038 After final ack, in_ready=1 for 5 cycles -> buffer_full=0 and out_ready=0 throughout, no word stored.
